multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the 8-bit processor. It sequences fetch, decode, execute, memory and writeback over several clocks, and handshakes with instruction and data memories through req/ready. It drives the same datapath controls as the single-cycle decoder: reg write, ALU source and op, mem write, mem-to-reg, r2 select and PC source. It also counts retired instructions and flags illegal opcodes and memory timeouts.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory req may wait for ready before entering ERROR (range 1..255).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  allows FETCH to start a new instruction; when 0, sequencer idles in FETCH
opcode  in  4  opcode field of the IR (valid from DECODE onward)
func  in  3  func field of the IR
zero  in  1  ALU zero flag, sampled in EXEC
imem_req  out  1  instruction fetch request
imem_ready  in  1  instruction memory data valid / accept
dmem_req  out  1  data memory request
dmem_ready  in  1  data memory complete
dmem_we  out  1  data memory write (store)
ir_we  out  1  load instruction register
pc_we  out  1  update PC
pc_src  out  2  00 pc+1, 01 branch target, 10 jump target
reg_write  out  1  register file write strobe
alu_src  out  1  0 = register, 1 = immediate
alu_ctrl  out  3  ALU operation
mem_to_reg  out  1  writeback from memory
r2_chooser  out  1  r2 address select (store / beq)
illegal  out  1  one-cycle pulse on undefined opcode or func
err  out  1  sticky, memory timeout
retired  out  CNT_W  retired-instruction count, wraps

Behaviour:
- Reset (async, any state): state FETCH; every output 0; retired 0; err 0; latched control word 0; wait counter 0.
- States: FETCH, DECODE, EXEC, MEM, WB, ERROR.
- Strobes not listed for a state are 0. alu_src, alu_ctrl, mem_to_reg and r2_chooser come from the control word latched in DECODE and are held from EXEC through WB.
- FETCH:
  - imem_req = run.
  - Cycle where imem_req && imem_ready: ir_we=1, pc_we=1, pc_src=00 (combinational from ready); next state DECODE.
  - run=0: stay, wait counter held at 0.
- DECODE (1 cycle): latch control word from instr_decoder.
  - Illegal: illegal=1 for this cycle, next FETCH, not retired.
  - Otherwise next EXEC.
- Decode map:
  - opcode 0000, func 000/001/010/100/101/110 -> alu_ctrl = func. func 011 and 111 are illegal.
  - 0100 addi: alu_src=1, alu_ctrl 000.
  - 1011 load: alu_src=1, mem_to_reg=1.
  - 1111 store: alu_src=1, r2_chooser=1.
  - 1000 beq: alu_ctrl 111, r2_chooser=1.
  - 0010 jump.
  - Any other opcode is illegal.
- EXEC (1 cycle):
  - R-type / addi -> WB.
  - load / store -> MEM.
  - beq: if zero, pc_we=1 and pc_src=01. Then FETCH, retired+1.
  - jump: pc_we=1, pc_src=10, then FETCH, retired+1.
- MEM:
  - dmem_req=1; dmem_we=1 for store.
  - On dmem_ready: load -> WB; store -> FETCH with retired+1.
- WB (1 cycle): reg_write=1, then FETCH, retired+1.
- Timeout: wait counter increments each cycle a req is high without ready and clears on ready or state change. When it reaches MEM_TIMEOUT, go to ERROR and set err=1. A ready arriving in that same cycle wins: normal handshake, no error.
- ERROR: all strobes 0, err=1; leaves only on rst.
- Minimum latency with zero-wait memory:
  - ALU/addi: 4 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
  - beq/jump: 3 cycles.
  - Illegal: 2 cycles.
- retired wraps from all-ones to 0 and increments at most once per instruction.

Decomposition:
- Package proc_ctrl_pkg:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LOAD, OP_STORE, OP_BEQ, OP_JUMP);
  - state enum;
  - pc_src enum;
  - ALU op codes;
  - packed control-word struct (alu_src, alu_ctrl, mem_to_reg, r2_chooser, class, illegal).
- Sub-module instr_decoder: purely combinational opcode/func -> control word. The FSM, timeout counter and retired counter live in multicycle_sequencer.

Test Plan:
1. rst, run=1, zero-wait mems; R-type opcode 0000 func 010 -> ir_we in cycle 0, alu_ctrl=010 in EXEC/WB, reg_write=1 in cycle 3, retired=1 after 4 cycles.
2. load 1011, dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then WB with mem_to_reg=1, reg_write=1; total 8 cycles.
3. beq 1000 with zero=1 -> pc_we=1, pc_src=01 in EXEC. Repeat with zero=0 -> pc_we=0. retired increments both times.
4. Opcode 0111, then opcode 0000 func 111 -> illegal pulses 1 cycle each, no reg_write/dmem_req, retired unchanged.
5. MEM_TIMEOUT=4, store with dmem_ready never asserted -> ERROR after 4 wait cycles, err=1 sticky, all strobes 0. Assert rst mid-ERROR -> err=0, state FETCH.
6. Preload retired to all-ones via 2^CNT_W-1 jumps (or CNT_W=4 build: 15 jumps), one more jump -> retired=0. Assert run=0 -> imem_req=0, no progress.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle processor control path: opcodes, ALU ops,
// FSM states, PC source select and the control word produced by the decoder.
package proc_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_LOAD  = 4'b1011;
    localparam logic [3:0] OP_STORE = 4'b1111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_JUMP  = 4'b0010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        PC_INC    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    typedef enum logic [2:0] {
        IC_ALU, IC_LOAD, IC_STORE, IC_BEQ, IC_JUMP
    } iclass_t;

    typedef struct packed {
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       mem_to_reg;
        logic       r2_chooser;
        iclass_t    iclass;
        logic       illegal;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Bundle of handshake, instruction-field and datapath-control signals between
// the sequencer (master) and the datapath / memories (slave).
interface multicycle_sequencer_if #(parameter int CNT_W = 16);
    logic             run;
    logic [3:0]       opcode;
    logic [2:0]       func;
    logic             zero;
    logic             imem_req;
    logic             imem_ready;
    logic             dmem_req;
    logic             dmem_ready;
    logic             dmem_we;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic             alu_src;
    logic [2:0]       alu_ctrl;
    logic             mem_to_reg;
    logic             r2_chooser;
    logic             illegal;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, opcode, func, zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_write,
               alu_src, alu_ctrl, mem_to_reg, r2_chooser, illegal, err, retired
    );

    modport slave (
        output run, opcode, func, zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_write,
               alu_src, alu_ctrl, mem_to_reg, r2_chooser, illegal, err, retired
    );
endinterface

// File: rtl/multicycle_sequencer_decoder.sv
// Combinational opcode/func decode into the control word latched by the sequencer.
module instr_decoder
    import proc_ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic [2:0] i_func,
    output ctrl_word_t o_cw
);

    always_comb begin
        o_cw        = '0;
        o_cw.iclass = IC_ALU;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_func)
                    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT: o_cw.alu_ctrl = i_func;
                    default: o_cw.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                o_cw.alu_src  = 1'b1;
                o_cw.alu_ctrl = ALU_ADD;
            end
            OP_LOAD: begin
                o_cw.alu_src    = 1'b1;
                o_cw.mem_to_reg = 1'b1;
                o_cw.iclass     = IC_LOAD;
            end
            OP_STORE: begin
                o_cw.alu_src    = 1'b1;
                o_cw.r2_chooser = 1'b1;
                o_cw.iclass     = IC_STORE;
            end
            OP_BEQ: begin
                o_cw.alu_ctrl   = ALU_CMP;
                o_cw.r2_chooser = 1'b1;
                o_cw.iclass     = IC_BEQ;
            end
            OP_JUMP:  o_cw.iclass  = IC_JUMP;
            default:  o_cw.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/writeback sequencing with
// req/ready memory handshakes, a wait-cycle timeout and a retired counter.
module multicycle_sequencer
    import proc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_sequencer_if.master bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state, w_next;
    ctrl_word_t       r_cw, w_cw;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_retired;
    logic             r_err;
    logic             w_retire, w_wait_inc, w_timeout;

    instr_decoder u_dec (
        .i_opcode (bus.opcode),
        .i_func   (bus.func),
        .o_cw     (w_cw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_cw      <= '0;
            r_wait    <= '0;
            r_retired <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_cw <= w_cw;
            r_wait <= w_wait_inc ? r_wait + 8'd1 : 8'd0;
            if (w_retire)  r_retired <= r_retired + CNT_W'(1);
            if (w_timeout) r_err     <= 1'b1;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_retire       = 1'b0;
        w_wait_inc     = 1'b0;
        w_timeout      = 1'b0;
        bus.imem_req   = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = PC_INC;
        bus.reg_write  = 1'b0;
        bus.alu_src    = 1'b0;
        bus.alu_ctrl   = 3'b000;
        bus.mem_to_reg = 1'b0;
        bus.r2_chooser = 1'b0;
        bus.illegal    = 1'b0;
        bus.err        = r_err;
        bus.retired    = r_retired;

        case (r_state)
            S_FETCH: begin
                bus.imem_req = bus.run;
                if (bus.run && bus.imem_ready) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    w_next    = S_DECODE;
                end else if (bus.run) begin
                    // a late ready on the final wait cycle still completes normally
                    if (r_wait == WAIT_LAST) begin
                        w_next    = S_ERROR;
                        w_timeout = 1'b1;
                    end else begin
                        w_wait_inc = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                bus.illegal = w_cw.illegal;
                w_next      = w_cw.illegal ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                case (r_cw.iclass)
                    IC_LOAD, IC_STORE: w_next = S_MEM;
                    IC_BEQ: begin
                        bus.pc_we  = bus.zero;
                        bus.pc_src = bus.zero ? PC_BRANCH : PC_INC;
                        w_next     = S_FETCH;
                        w_retire   = 1'b1;
                    end
                    IC_JUMP: begin
                        bus.pc_we  = 1'b1;
                        bus.pc_src = PC_JUMP;
                        w_next     = S_FETCH;
                        w_retire   = 1'b1;
                    end
                    default: w_next = r_cw.illegal ? S_FETCH : S_WB;
                endcase
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (r_cw.iclass == IC_STORE);
                if (bus.dmem_ready) begin
                    w_next   = (r_cw.iclass == IC_STORE) ? S_FETCH : S_WB;
                    w_retire = (r_cw.iclass == IC_STORE);
                end else if (r_wait == WAIT_LAST) begin
                    w_next    = S_ERROR;
                    w_timeout = 1'b1;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_WB: begin
                bus.reg_write = 1'b1;
                w_next        = S_FETCH;
                w_retire      = 1'b1;
            end
            default: w_next = S_ERROR;
        endcase

        // datapath selects follow the latched word only while an instruction executes
        if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
            bus.alu_src    = r_cw.alu_src;
            bus.alu_ctrl   = r_cw.alu_ctrl;
            bus.mem_to_reg = r_cw.mem_to_reg;
            bus.r2_chooser = r_cw.r2_chooser;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer built with MEM_TIMEOUT=4, CNT_W=4.
module tb_multicycle_sequencer;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_sequencer_if #(.CNT_W(4)) bus ();

    multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // present an instruction in FETCH, check the IR load strobes, advance to DECODE
    task automatic fetch(input logic [3:0] op, input logic [2:0] fn);
        bus.opcode = op;
        bus.func   = fn;
        bus.run    = 1'b1;
        #1;
        check("fetch imem_req", bus.imem_req, 1);
        check("fetch ir_we", bus.ir_we, 1);
        check("fetch pc_we", bus.pc_we, 1);
        check("fetch pc_src", bus.pc_src, 0);
        tick();
        bus.run = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.run        = 1'b0;
        bus.opcode     = 4'b0000;
        bus.func       = 3'b000;
        bus.zero       = 1'b0;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        #12;
        check("rst imem_req", bus.imem_req, 0);
        check("rst ir_we", bus.ir_we, 0);
        check("rst reg_write", bus.reg_write, 0);
        check("rst alu_ctrl", bus.alu_ctrl, 0);
        check("rst err", bus.err, 0);
        check("rst retired", bus.retired, 0);
        tick();
        rst = 1'b0;

        // R-type AND: 4 cycles, retired 0 -> 1
        fetch(4'b0000, 3'b010);
        #1; check("rtype dec illegal", bus.illegal, 0);
        check("rtype dec reg_write", bus.reg_write, 0);
        tick();
        #1; check("rtype exec alu_ctrl", bus.alu_ctrl, 3'b010);
        check("rtype exec reg_write", bus.reg_write, 0);
        tick();
        #1; check("rtype wb reg_write", bus.reg_write, 1);
        check("rtype wb alu_ctrl", bus.alu_ctrl, 3'b010);
        check("rtype wb retired", bus.retired, 0);
        tick();
        #1; check("rtype retired", bus.retired, 1);
        check("idle imem_req", bus.imem_req, 0);

        // load with three wait cycles; ready lands on the last allowed cycle
        fetch(4'b1011, 3'b000);
        tick();
        #1; check("load exec alu_src", bus.alu_src, 1);
        check("load exec mem_to_reg", bus.mem_to_reg, 1);
        check("load exec dmem_req", bus.dmem_req, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1; check("load mem dmem_req", bus.dmem_req, 1);
            check("load mem dmem_we", bus.dmem_we, 0);
            check("load mem err", bus.err, 0);
            tick();
        end
        bus.dmem_ready = 1'b1;
        #1; check("load mem ready dmem_req", bus.dmem_req, 1);
        tick();
        bus.dmem_ready = 1'b0;
        #1; check("load wb reg_write", bus.reg_write, 1);
        check("load wb mem_to_reg", bus.mem_to_reg, 1);
        check("load wb dmem_req", bus.dmem_req, 0);
        tick();
        #1; check("load retired", bus.retired, 2);
        check("load err", bus.err, 0);

        // beq taken then not taken
        fetch(4'b1000, 3'b000);
        tick();
        bus.zero = 1'b1;
        #1; check("beq1 pc_we", bus.pc_we, 1);
        check("beq1 pc_src", bus.pc_src, 2'b01);
        check("beq1 alu_ctrl", bus.alu_ctrl, 3'b111);
        check("beq1 r2_chooser", bus.r2_chooser, 1);
        tick();
        #1; check("beq1 retired", bus.retired, 3);
        fetch(4'b1000, 3'b000);
        tick();
        bus.zero = 1'b0;
        #1; check("beq0 pc_we", bus.pc_we, 0);
        check("beq0 pc_src", bus.pc_src, 2'b00);
        tick();
        #1; check("beq0 retired", bus.retired, 4);

        // illegal opcode and illegal R-type func
        fetch(4'b0111, 3'b000);
        #1; check("ill op illegal", bus.illegal, 1);
        check("ill op dmem_req", bus.dmem_req, 0);
        tick();
        #1; check("ill op after illegal", bus.illegal, 0);
        check("ill op reg_write", bus.reg_write, 0);
        check("ill op retired", bus.retired, 4);
        fetch(4'b0000, 3'b111);
        #1; check("ill func illegal", bus.illegal, 1);
        tick();
        #1; check("ill func after illegal", bus.illegal, 0);
        check("ill func reg_write", bus.reg_write, 0);
        check("ill func retired", bus.retired, 4);

        // jumps drive retired from 4 up to 15, then wrap to 0
        for (int j = 0; j < 11; j++) begin
            fetch(4'b0010, 3'b000);
            tick();
            #1; check("jump pc_we", bus.pc_we, 1);
            check("jump pc_src", bus.pc_src, 2'b10);
            tick();
        end
        #1; check("jump retired max", bus.retired, 15);
        fetch(4'b0010, 3'b000);
        tick();
        tick();
        #1; check("jump retired wrap", bus.retired, 0);
        check("run0 imem_req", bus.imem_req, 0);
        tick();
        tick();
        #1; check("run0 ir_we", bus.ir_we, 0);
        check("run0 retired", bus.retired, 0);

        // store whose memory never answers: ERROR after 4 wait cycles
        fetch(4'b1111, 3'b000);
        tick();
        #1; check("store exec alu_src", bus.alu_src, 1);
        check("store exec r2_chooser", bus.r2_chooser, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            #1; check("store mem dmem_req", bus.dmem_req, 1);
            check("store mem dmem_we", bus.dmem_we, 1);
            check("store mem err", bus.err, 0);
            tick();
        end
        #1; check("error err", bus.err, 1);
        check("error dmem_req", bus.dmem_req, 0);
        check("error dmem_we", bus.dmem_we, 0);
        check("error alu_src", bus.alu_src, 0);
        check("error r2_chooser", bus.r2_chooser, 0);
        bus.run        = 1'b1;
        bus.dmem_ready = 1'b1;
        tick();
        tick();
        #1; check("error sticky err", bus.err, 1);
        check("error imem_req", bus.imem_req, 0);
        check("error ir_we", bus.ir_we, 0);
        check("error retired", bus.retired, 0);
        bus.dmem_ready = 1'b0;
        rst = 1'b1;
        #1; check("mid-error rst err", bus.err, 0);
        #2;
        rst = 1'b0;
        #1; check("post rst imem_req", bus.imem_req, 1);
        check("post rst ir_we", bus.ir_we, 1);
        bus.run = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
